// File: rtl/skut_frame_receiver.sv
// -----------------------------------------------------------------------------
// skut_frame_receiver
//
// Receive side of the SKUT telemetry link. Takes the 8-bit sample stream from
// the ADC sampler, hunts for the two-word frame marker and writes each 128-word
// frame into one half of a ping-pong buffer pair. Isolated marker errors are
// flywheeled through. Lock is dropped after MISS_MAX consecutive bad markers,
// or when the strobe stream goes quiet for TIMEOUT clocks.
//
// Ports
//   clk          in   1   system clock
//   reset        in   1   asynchronous reset, active-low
//   i_stb        in   1   sample strobe, one-clk pulse per sample
//   i_data       in   8   sample value, valid with i_stb
//   o_wr_addr    out  7   buffer write address
//   o_wr_data    out  8   buffer write data
//   o_wr_en      out  1   buffer write enable, one-clk pulse
//   o_wr_bank    out  1   bank currently being written
//   o_rd_bank    out  1   bank holding the last complete frame (~o_wr_bank)
//   o_frame_done out  1   one-clk pulse: a complete frame sits in o_rd_bank
//   o_locked     out  1   receiver in lock
//   o_err_cnt    out  16  bad-marker count, saturating
// -----------------------------------------------------------------------------
module skut_frame_receiver #(
  parameter logic [7:0] SYNC0    = 8'hFF,
  parameter logic [7:0] SYNC1    = 8'h3C,
  parameter int         MISS_MAX = 3,
  parameter int         TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_stb,
  input  logic [7:0]  i_data,
  output logic [6:0]  o_wr_addr,
  output logic [7:0]  o_wr_data,
  output logic        o_wr_en,
  output logic        o_wr_bank,
  output logic        o_rd_bank,
  output logic        o_frame_done,
  output logic        o_locked,
  output logic [15:0] o_err_cnt
);

  localparam int              TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TMO_MAX  = TW'(TIMEOUT);
  localparam logic [3:0]      MISS_LIM = 4'(MISS_MAX);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CAPTURE = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t        state_reg,      state_next;
  logic [7:0]    prev_reg,       prev_next;
  logic [6:0]    addr_reg,       addr_next;
  logic          sync1_pend_reg, sync1_pend_next;
  logic          defer_reg,      defer_next;
  logic [7:0]    defer_data_reg, defer_data_next;
  logic          done_arm_reg,   done_arm_next;
  logic          bad_reg,        bad_next;
  logic [3:0]    miss_reg,       miss_next;
  logic [TW-1:0] tmo_reg,        tmo_next;
  logic [6:0]    wr_addr_reg,    wr_addr_next;
  logic [7:0]    wr_data_reg,    wr_data_next;
  logic          wr_en_reg,      wr_en_next;
  logic          wr_bank_reg,    wr_bank_next;
  logic          frame_done_reg, frame_done_next;
  logic          locked_reg,     locked_next;
  logic [15:0]   err_cnt_reg,    err_cnt_next;

  // A strobe that lands on the SYNC1 write slot is parked in defer_reg and
  // replayed on the following clock. While that slot is busy no sample is
  // taken.
  logic       stb_eff;
  logic [7:0] sample_eff;
  logic       timed_out;
  logic [3:0] miss_inc;

  assign stb_eff    = !sync1_pend_reg && (i_stb || defer_reg);
  assign sample_eff = defer_reg ? defer_data_reg : i_data;
  assign timed_out  = (tmo_reg == TMO_MAX);
  assign miss_inc   = miss_reg + 4'd1;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= HUNT;
      prev_reg       <= 8'd0;
      addr_reg       <= 7'd0;
      sync1_pend_reg <= 1'b0;
      defer_reg      <= 1'b0;
      defer_data_reg <= 8'd0;
      done_arm_reg   <= 1'b0;
      bad_reg        <= 1'b0;
      miss_reg       <= 4'd0;
      tmo_reg        <= '0;
      wr_addr_reg    <= 7'd0;
      wr_data_reg    <= 8'd0;
      wr_en_reg      <= 1'b0;
      wr_bank_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      locked_reg     <= 1'b0;
      err_cnt_reg    <= 16'd0;
    end else begin
      state_reg      <= state_next;
      prev_reg       <= prev_next;
      addr_reg       <= addr_next;
      sync1_pend_reg <= sync1_pend_next;
      defer_reg      <= defer_next;
      defer_data_reg <= defer_data_next;
      done_arm_reg   <= done_arm_next;
      bad_reg        <= bad_next;
      miss_reg       <= miss_next;
      tmo_reg        <= tmo_next;
      wr_addr_reg    <= wr_addr_next;
      wr_data_reg    <= wr_data_next;
      wr_en_reg      <= wr_en_next;
      wr_bank_reg    <= wr_bank_next;
      frame_done_reg <= frame_done_next;
      locked_reg     <= locked_next;
      err_cnt_reg    <= err_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    prev_next       = prev_reg;
    addr_next       = addr_reg;
    sync1_pend_next = 1'b0;
    defer_next      = 1'b0;
    defer_data_next = defer_data_reg;
    done_arm_next   = 1'b0;
    bad_next        = bad_reg;
    miss_next       = miss_reg;
    wr_addr_next    = wr_addr_reg;
    wr_data_next    = wr_data_reg;
    wr_en_next      = 1'b0;
    wr_bank_next    = wr_bank_reg;
    frame_done_next = 1'b0;
    locked_next     = locked_reg;
    err_cnt_next    = err_cnt_reg;

    // Dead-stream watchdog: cleared by every real strobe, saturating.
    if (i_stb) begin
      tmo_next = '0;
    end else if (timed_out) begin
      tmo_next = tmo_reg;
    end else begin
      tmo_next = tmo_reg + TW'(1);
    end

    // The done pulse and the bank flip trail the address-127 write by one
    // clock, so that last word still lands in the bank it belongs to.
    if (done_arm_reg) begin
      frame_done_next = 1'b1;
      wr_bank_next    = ~wr_bank_reg;
    end

    if (sync1_pend_reg) begin
      // Second half of the marker write-back after a HUNT detection.
      wr_en_next      = 1'b1;
      wr_addr_next    = 7'd1;
      wr_data_next    = SYNC1;
      addr_next       = 7'd2;
      defer_next      = i_stb;
      defer_data_next = i_data;
    end else if (timed_out && (state_reg != HUNT)) begin
      state_next  = HUNT;
      locked_next = 1'b0;
      miss_next   = 4'd0;
      addr_next   = 7'd0;
    end else if (stb_eff) begin
      prev_next = sample_eff;
      case (state_reg)
        HUNT: begin
          if ((prev_reg == SYNC0) && (sample_eff == SYNC1)) begin
            wr_en_next      = 1'b1;
            wr_addr_next    = 7'd0;
            wr_data_next    = SYNC0;
            sync1_pend_next = 1'b1;
            state_next      = CAPTURE;
          end
        end

        CAPTURE: begin
          wr_en_next   = 1'b1;
          wr_addr_next = addr_reg;
          wr_data_next = sample_eff;
          if (addr_reg == 7'd127) begin
            done_arm_next = 1'b1;
            addr_next     = 7'd0;
            state_next    = CHECK;
          end else begin
            addr_next = addr_reg + 7'd1;
          end
        end

        CHECK: begin
          // Marker words go into the new bank regardless of their value.
          wr_en_next   = 1'b1;
          wr_addr_next = addr_reg;
          wr_data_next = sample_eff;
          if (addr_reg == 7'd0) begin
            bad_next  = (sample_eff != SYNC0);
            addr_next = 7'd1;
          end else begin
            addr_next  = 7'd2;
            state_next = CAPTURE;
            if (!bad_reg && (sample_eff == SYNC1)) begin
              miss_next   = 4'd0;
              locked_next = 1'b1;
            end else begin
              if (err_cnt_reg != 16'hFFFF) begin
                err_cnt_next = err_cnt_reg + 16'd1;
              end
              if (miss_inc == MISS_LIM) begin
                locked_next = 1'b0;
                miss_next   = 4'd0;
                addr_next   = 7'd0;
                state_next  = HUNT;
              end else begin
                miss_next = miss_inc;
              end
            end
          end
        end

        default: state_next = HUNT;
      endcase
    end
  end

  assign o_wr_addr    = wr_addr_reg;
  assign o_wr_data    = wr_data_reg;
  assign o_wr_en      = wr_en_reg;
  assign o_wr_bank    = wr_bank_reg;
  assign o_rd_bank    = ~wr_bank_reg;
  assign o_frame_done = frame_done_reg;
  assign o_locked     = locked_reg;
  assign o_err_cnt    = err_cnt_reg;

endmodule
